bus_pack_16_to_48: RTL and testbench



---
 rtl/bus_pack_16_to_48_pkg.sv | 27 ++
 rtl/bus_pack_16_to_48_if.sv | 31 +++
 rtl/bus_pack_16_to_48.sv | 181 ++++++++++++++++++
 tb/tb_bus_pack_16_to_48.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pack_16_to_48_pkg.sv
// Shared types and constants for the 16-to-48 bit packet packer.
package bus_pack_16_to_48_pkg;

  localparam int WORD_W     = 16;
  localparam int BEAT_WORDS = 3;
  localparam int MTY_W      = 3;
  localparam int BEAT_W     = WORD_W * BEAT_WORDS;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_e;

  // Word k of a beat occupies the k-th 16-bit slot counted from the MSB end.
  function automatic logic [BEAT_W-1:0] place_word(input logic [WORD_W-1:0] w,
                                                   input logic [1:0]        slot);
    logic [BEAT_W-1:0] b;
    b = '0;
    case (slot)
      2'd0:    b[47:32] = w;
      2'd1:    b[31:16] = w;
      default: b[15:0]  = w;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/bus_pack_16_to_48_if.sv
// Source/sink bundle of the 16-to-48 packer: 16-bit packet input, 48-bit beat output, FIFO fill.
interface bus_pack_16_to_48_if
  import bus_pack_16_to_48_pkg::*;
#(
  parameter int USEDW_W = 9
);

  logic [WORD_W-1:0]  din;
  logic               din_vld;
  logic               din_sop;
  logic               din_eop;
  logic               din_rdy;
  logic [USEDW_W-1:0] wr_usedw;
  logic [BEAT_W-1:0]  dout;
  logic               dout_vld;
  logic               dout_sop;
  logic               dout_eop;
  logic [MTY_W-1:0]   dout_mty;
  logic               pkt_err;

  modport master (
    output din, din_vld, din_sop, din_eop, wr_usedw,
    input  din_rdy, dout, dout_vld, dout_sop, dout_eop, dout_mty, pkt_err
  );

  modport slave (
    input  din, din_vld, din_sop, din_eop, wr_usedw,
    output din_rdy, dout, dout_vld, dout_sop, dout_eop, dout_mty, pkt_err
  );

endinterface

// File: rtl/bus_pack_16_to_48.sv
// Packs a 16-bit sop/eop packet stream into 48-bit beats with an empty-word count.
// Optional framing checks enabled by defining PKT_ERR_CHK_EN.
//
// state   | meaning
// ST_IDLE | between packets; only a sop word is accepted
// ST_PKT  | inside a packet; words fill slots 0..2 of the current beat
module bus_pack_16_to_48
  import bus_pack_16_to_48_pkg::*;
#(
  parameter int USEDW_W = 9,
  parameter int RDY_THR = 500
) (
  input  logic                clk,
  input  logic                rst,
  bus_pack_16_to_48_if.slave  bus
);

  localparam logic [USEDW_W-1:0] THR = USEDW_W'(RDY_THR);

  state_e             state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [BEAT_W-1:0]  shreg_q, shreg_d;
  logic               first_q, first_d;
  logic               rdy_q;
  logic [BEAT_W-1:0]  dout_q, dout_d;
  logic               vld_q, vld_d;
  logic               sop_q, sop_d;
  logic               eop_q, eop_d;
  logic [MTY_W-1:0]   mty_q, mty_d;
  logic               err_q, err_d;
  logic [BEAT_W-1:0]  beat;
`ifdef PKT_ERR_CHK_EN
  logic               pend_q, pend_d;
  logic [WORD_W-1:0]  pend_word_q, pend_word_d;
  logic               busy;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      first_q <= 1'b0;
      rdy_q   <= 1'b0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      mty_q   <= '0;
      err_q   <= 1'b0;
`ifdef PKT_ERR_CHK_EN
      pend_q      <= 1'b0;
      pend_word_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      first_q <= first_d;
      rdy_q   <= (bus.wr_usedw < THR);
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      mty_q   <= mty_d;
      err_q   <= err_d;
`ifdef PKT_ERR_CHK_EN
      pend_q      <= pend_d;
      pend_word_q <= pend_word_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.din_vld) begin
      if (bus.din_sop)
        state_d = bus.din_eop ? ST_IDLE : ST_PKT;
      else if (state_q == ST_PKT && bus.din_eop)
        state_d = ST_IDLE;
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    first_d = first_q;
    dout_d  = dout_q;
    vld_d   = 1'b0;
    sop_d   = sop_q;
    eop_d   = eop_q;
    mty_d   = mty_q;
    err_d   = 1'b0;
    beat    = shreg_q | place_word(bus.din, cnt_q);
`ifdef PKT_ERR_CHK_EN
    pend_d      = 1'b0;
    pend_word_d = pend_word_q;
    busy        = 1'b0;
    // A 1-word packet that collided with an error beat goes out one cycle late.
    if (pend_q) begin
      vld_d  = 1'b1;
      dout_d = {pend_word_q, 32'b0};
      sop_d  = 1'b1;
      eop_d  = 1'b1;
      mty_d  = 3'd2;
      busy   = 1'b1;
    end
`endif
    if (bus.din_vld) begin
      if (bus.din_sop) begin
`ifdef PKT_ERR_CHK_EN
        if (state_q == ST_PKT) begin
          err_d = 1'b1;
          if (cnt_q != 2'd0) begin
            vld_d  = 1'b1;
            dout_d = shreg_q;
            sop_d  = first_q;
            eop_d  = 1'b1;
            mty_d  = (cnt_q == 2'd1) ? 3'd2 : 3'd1;
            busy   = 1'b1;
          end
        end
`endif
        if (bus.din_eop) begin
          cnt_d   = '0;
          shreg_d = '0;
          first_d = 1'b0;
`ifdef PKT_ERR_CHK_EN
          if (busy) begin
            pend_d      = 1'b1;
            pend_word_d = bus.din;
          end else begin
            vld_d  = 1'b1;
            dout_d = {bus.din, 32'b0};
            sop_d  = 1'b1;
            eop_d  = 1'b1;
            mty_d  = 3'd2;
          end
`else
          vld_d  = 1'b1;
          dout_d = {bus.din, 32'b0};
          sop_d  = 1'b1;
          eop_d  = 1'b1;
          mty_d  = 3'd2;
`endif
        end else begin
          cnt_d   = 2'd1;
          shreg_d = {bus.din, 32'b0};
          first_d = 1'b1;
        end
      end else if (state_q == ST_PKT) begin
        if (bus.din_eop || cnt_q == 2'd2) begin
          vld_d   = 1'b1;
          dout_d  = beat;
          sop_d   = first_q;
          eop_d   = bus.din_eop;
          mty_d   = bus.din_eop ? {1'b0, 2'd2 - cnt_q} : 3'd0;
          cnt_d   = '0;
          shreg_d = '0;
          first_d = 1'b0;
        end else begin
          shreg_d = beat;
          cnt_d   = cnt_q + 2'd1;
        end
      end else begin
`ifdef PKT_ERR_CHK_EN
        err_d = 1'b1;
`endif
      end
    end
  end

  assign bus.din_rdy  = rdy_q;
  assign bus.dout     = dout_q;
  assign bus.dout_vld = vld_q;
  assign bus.dout_sop = sop_q;
  assign bus.dout_eop = eop_q;
  assign bus.dout_mty = mty_q;
  assign bus.pkt_err  = err_q;

endmodule

// File: tb/tb_bus_pack_16_to_48.sv
// Bench for bus_pack_16_to_48: packet-level model compared every cycle, plus literal beat checks.
module tb_bus_pack_16_to_48;

  typedef struct {
    logic [47:0] d;
    logic        s;
    logic        e;
    logic [2:0]  m;
    logic        err;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_pack_16_to_48_if #(.USEDW_W(9)) bus();

  bus_pack_16_to_48 #(.USEDW_W(9), .RDY_THR(500)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [47:0] exp_dout = '0;
  logic        exp_vld  = 1'b0;
  logic        exp_sop  = 1'b0;
  logic        exp_eop  = 1'b0;
  logic [2:0]  exp_mty  = '0;
  logic        exp_err  = 1'b0;
  logic        exp_rdy  = 1'b0;

  logic [15:0] m_words[$];
  bit          m_in_pkt;
  bit          m_first;
  bit          m_busy;
  bit          m_pend;
  beat_t       m_pend_beat;
  beat_t       log_q[$];
  bit          chk_on = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic m_set_out(input beat_t b);
    exp_vld  = 1'b1;
    exp_dout = b.d;
    exp_sop  = b.s;
    exp_eop  = b.e;
    exp_mty  = b.m;
  endtask

  // Close the beat collected so far: words fill from the MSB, empty slots stay zero.
  task automatic m_emit(input bit eop_f);
    beat_t b;
    b.d = '0;
    for (int i = 0; i < m_words.size(); i++) b.d[47-16*i -: 16] = m_words[i];
    b.s   = m_first;
    b.e   = eop_f;
    b.m   = 3'(3 - m_words.size());
    b.err = 1'b0;
    m_words.delete();
    m_first = 1'b0;
    if (m_busy) begin
      m_pend      = 1'b1;
      m_pend_beat = b;
    end else begin
      m_set_out(b);
      m_busy = 1'b1;
    end
  endtask

  task automatic model_step();
    if (rst) begin
      exp_dout = '0; exp_vld = 0; exp_sop = 0; exp_eop = 0; exp_mty = '0;
      exp_err = 0; exp_rdy = 0;
      m_words.delete(); m_in_pkt = 0; m_first = 0; m_pend = 0;
      return;
    end
    exp_rdy = (bus.wr_usedw < 9'd500);
    exp_vld = 1'b0;
    exp_err = 1'b0;
    m_busy  = 1'b0;
    if (m_pend) begin
      m_set_out(m_pend_beat);
      m_pend = 1'b0;
      m_busy = 1'b1;
    end
    if (bus.din_vld) begin
      if (bus.din_sop) begin
`ifdef PKT_ERR_CHK_EN
        if (m_in_pkt) begin
          exp_err = 1'b1;
          if (m_words.size() > 0) m_emit(1'b1);
        end
`endif
        m_words.delete();
        m_words.push_back(bus.din);
        m_first  = 1'b1;
        m_in_pkt = 1'b1;
        if (bus.din_eop) begin
          m_emit(1'b1);
          m_in_pkt = 1'b0;
        end
      end else if (m_in_pkt) begin
        m_words.push_back(bus.din);
        if (bus.din_eop || m_words.size() == 3) m_emit(bus.din_eop);
        if (bus.din_eop) m_in_pkt = 1'b0;
      end else begin
`ifdef PKT_ERR_CHK_EN
        exp_err = 1'b1;
`endif
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("din_rdy",  {63'b0, bus.din_rdy},  {63'b0, exp_rdy});
      chk("dout_vld", {63'b0, bus.dout_vld}, {63'b0, exp_vld});
      chk("pkt_err",  {63'b0, bus.pkt_err},  {63'b0, exp_err});
      chk("dout",     {16'b0, bus.dout},     {16'b0, exp_dout});
      chk("dout_sop", {63'b0, bus.dout_sop}, {63'b0, exp_sop});
      chk("dout_eop", {63'b0, bus.dout_eop}, {63'b0, exp_eop});
      chk("dout_mty", {61'b0, bus.dout_mty}, {61'b0, exp_mty});
      if (bus.dout_vld === 1'b1)
        log_q.push_back('{bus.dout, bus.dout_sop, bus.dout_eop, bus.dout_mty, bus.pkt_err});
    end
  end

  task automatic cyc(input bit v, input bit s, input bit e, input logic [15:0] d);
    bus.din_vld = v;
    bus.din_sop = s;
    bus.din_eop = e;
    bus.din     = d;
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 16'h0);
  endtask

  task automatic chk_beat(input string nm, input int idx, input logic [47:0] d,
                          input logic s, input logic e, input logic [2:0] m);
    chk({nm, "_present"}, {63'b0, (log_q.size() > idx)}, 64'd1);
    if (log_q.size() > idx) begin
      chk({nm, "_data"}, {16'b0, log_q[idx].d}, {16'b0, d});
      chk({nm, "_sop"},  {63'b0, log_q[idx].s}, {63'b0, s});
      chk({nm, "_eop"},  {63'b0, log_q[idx].e}, {63'b0, e});
      chk({nm, "_mty"},  {61'b0, log_q[idx].m}, {61'b0, m});
    end
  endtask

  int n0;

  initial begin
    rst = 1'b1;
    bus.wr_usedw = 9'd0;
    bus.din_vld = 0; bus.din_sop = 0; bus.din_eop = 0; bus.din = '0;
    chk_on = 1'b1;
    idle(3);
    chk("reset_dout", {16'b0, bus.dout}, 64'd0);
    chk("reset_rdy",  {63'b0, bus.din_rdy}, 64'd0);
    rst = 1'b0;
    idle(2);
    chk("rdy_after_reset", {63'b0, bus.din_rdy}, 64'd1);

    // 6-word packet -> two full beats
    n0 = log_q.size();
    cyc(1, 1, 0, 16'h0001);
    for (int i = 2; i <= 5; i++) cyc(1, 0, 0, 16'(i));
    cyc(1, 0, 1, 16'h0006);
    idle(2);
    chk("t1_nbeats", 64'(log_q.size() - n0), 64'd2);
    chk_beat("t1_b0", n0,     48'h000100020003, 1, 0, 3'd0);
    chk_beat("t1_b1", n0 + 1, 48'h000400050006, 0, 1, 3'd0);

    // 4-word packet -> full beat then 1-word tail
    n0 = log_q.size();
    cyc(1, 1, 0, 16'h000A);
    cyc(1, 0, 0, 16'h000B);
    cyc(1, 0, 0, 16'h000C);
    cyc(1, 0, 1, 16'h000D);
    idle(2);
    chk_beat("t2_b0", n0,     48'h000A000B000C, 1, 0, 3'd0);
    chk_beat("t2_b1", n0 + 1, 48'h000D00000000, 0, 1, 3'd2);
    chk("t2_hold_dout", {16'b0, bus.dout}, {16'b0, 48'h000D00000000});

    // 1-word packet, then a stray non-sop word in IDLE
    n0 = log_q.size();
    cyc(1, 1, 1, 16'h1234);
    chk_beat("t3_b0", n0, 48'h123400000000, 1, 1, 3'd2);
    cyc(1, 0, 0, 16'h0099);
`ifdef PKT_ERR_CHK_EN
    chk("t3_stray_err", {63'b0, bus.pkt_err}, 64'd1);
`else
    chk("t3_stray_err", {63'b0, bus.pkt_err}, 64'd0);
`endif
    idle(2);
    chk("t3_nbeats", 64'(log_q.size() - n0), 64'd1);

    // usedw threshold sweep; words sent while rdy=0 still pack
    bus.wr_usedw = 9'd499;
    idle(1);
    chk("t4_rdy_499", {63'b0, bus.din_rdy}, 64'd1);
    bus.wr_usedw = 9'd500;
    idle(1);
    chk("t4_rdy_500", {63'b0, bus.din_rdy}, 64'd0);
    n0 = log_q.size();
    cyc(1, 1, 0, 16'h0A01);
    cyc(1, 0, 0, 16'h0A02);
    cyc(1, 0, 1, 16'h0A03);
    chk_beat("t4_b0", n0, 48'h0A010A020A03, 1, 1, 3'd0);
    bus.wr_usedw = 9'd499;
    idle(1);
    chk("t4_rdy_back", {63'b0, bus.din_rdy}, 64'd1);

    // sop inside a packet
    n0 = log_q.size();
    cyc(1, 1, 0, 16'h0011);
    cyc(1, 0, 0, 16'h0022);
    cyc(1, 1, 0, 16'h0033);
    cyc(1, 0, 0, 16'h0044);
    cyc(1, 0, 1, 16'h0055);
    idle(2);
`ifdef PKT_ERR_CHK_EN
    chk("t5_nbeats", 64'(log_q.size() - n0), 64'd2);
    chk_beat("t5_err", n0, 48'h001100220000, 1, 1, 3'd1);
    if (log_q.size() > n0) chk("t5_err_flag", {63'b0, log_q[n0].err}, 64'd1);
    chk_beat("t5_new", n0 + 1, 48'h003300440055, 1, 1, 3'd0);
`else
    chk("t5_nbeats", 64'(log_q.size() - n0), 64'd1);
    chk_beat("t5_new", n0, 48'h003300440055, 1, 1, 3'd0);
`endif

    // reset mid-packet
    n0 = log_q.size();
    cyc(1, 1, 0, 16'h0061);
    cyc(1, 0, 0, 16'h0062);
    rst = 1'b1;
    idle(1);
    chk("t6_dout_zero", {16'b0, bus.dout}, 64'd0);
    chk("t6_eop_zero",  {63'b0, bus.dout_eop}, 64'd0);
    chk("t6_no_beat", 64'(log_q.size() - n0), 64'd0);
    rst = 1'b0;
    idle(1);
    cyc(1, 1, 0, 16'h0071);
    cyc(1, 0, 0, 16'h0072);
    cyc(1, 0, 1, 16'h0073);
    idle(2);
    chk_beat("t6_b0", n0, 48'h007100720073, 1, 1, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
